// File: rtl/add_round_key_stream.sv
// ---------------------------------------------------------------------------
// add_round_key_stream
//
// Streaming AES AddRoundKey stage. A block of BLOCK_BYTES bytes arrives as
// BEATS = BLOCK_BYTES/LANE_BYTES beats of state bytes plus matching round-key
// bytes. The block is buffered (LOAD), then emitted beat by beat as
// state XOR key (DRAIN). A block may reuse the previously stored round key
// through key_keep, sampled on the first beat of that block.
//
// Ports
//   clk        : single clock, rising edge
//   rst_n      : synchronous active-low reset
//   din        : state beat, byte i on bits [8i+7:8i]
//   key        : round-key beat, sampled together with din
//   key_keep   : on first beat of a block, 1 = reuse stored key
//   in_valid   : din/key/key_keep valid
//   in_ready   : high while loading a block
//   dout       : din XOR key beat, forced to 0 while out_valid is low
//   out_valid  : dout valid (high while draining a block)
//   out_ready  : downstream accepts dout
//   out_last   : final beat of the block on dout
//   blk_count  : blocks fully drained since reset, wraps at 16 bits
// ---------------------------------------------------------------------------
module add_round_key_stream #(
  parameter int LANE_BYTES  = 1,
  parameter int BLOCK_BYTES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [8*LANE_BYTES-1:0] din,
  input  logic [8*LANE_BYTES-1:0] key,
  input  logic                    key_keep,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [8*LANE_BYTES-1:0] dout,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic [15:0]             blk_count
);

  localparam int W     = 8 * LANE_BYTES;
  localparam int BEATS = BLOCK_BYTES / LANE_BYTES;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  // Buffers are sized to the full counter range so every index is in bounds.
  localparam int DEPTH = 1 << CW;
  localparam logic [CW-1:0] LAST_IDX = CW'(BEATS - 1);

  generate
    if ((BLOCK_BYTES % LANE_BYTES) != 0) begin : g_bad_block
      $error("add_round_key_stream: BLOCK_BYTES must be a multiple of LANE_BYTES");
    end
    if (!(LANE_BYTES == 1 || LANE_BYTES == 2 || LANE_BYTES == 4 ||
          LANE_BYTES == 8 || LANE_BYTES == 16)) begin : g_bad_lane
      $error("add_round_key_stream: LANE_BYTES must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  typedef enum logic {
    LOAD  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   wr_cnt_q, wr_cnt_d;
  logic [CW-1:0]   rd_cnt_q, rd_cnt_d;
  logic            key_loaded_q, key_loaded_d;
  logic            reuse_q, reuse_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic            out_last_q, out_last_d;
  logic [15:0]     blk_count_q, blk_count_d;

  logic [W-1:0]    data_buf [DEPTH];
  logic [W-1:0]    key_buf  [DEPTH];

  logic            in_xfer;
  logic            out_xfer;
  logic            reuse_eff;
  logic            key_we;

  // Bytewise XOR of a state beat with a key beat; zero when nothing is valid
  // so idle cycles never expose buffer contents.
  function automatic logic [W-1:0] add_key(input logic [W-1:0] state_beat,
                                           input logic [W-1:0] key_beat,
                                           input logic         vld);
    return vld ? (state_beat ^ key_beat) : '0;
  endfunction

  always_comb begin
    in_xfer  = in_valid && in_ready_q;
    out_xfer = out_valid_q && out_ready;
    // The reuse decision for the first beat is taken straight from the inputs
    // so that beat's key write is already suppressed; later beats use the
    // latched decision. Reuse is impossible before any full key exists.
    reuse_eff = (wr_cnt_q == '0) ? (key_keep && key_loaded_q) : reuse_q;
    key_we    = in_xfer && !reuse_eff;
  end

  always_comb begin
    state_d      = state_q;
    wr_cnt_d     = wr_cnt_q;
    rd_cnt_d     = rd_cnt_q;
    key_loaded_d = key_loaded_q;
    reuse_d      = reuse_q;
    in_ready_d   = in_ready_q;
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;
    blk_count_d  = blk_count_q;

    case (state_q)
      LOAD: begin
        if (in_xfer) begin
          if (wr_cnt_q == '0) begin
            reuse_d = key_keep && key_loaded_q;
          end
          if (wr_cnt_q == LAST_IDX) begin
            state_d      = DRAIN;
            wr_cnt_d     = '0;
            rd_cnt_d     = '0;
            key_loaded_d = 1'b1;
            in_ready_d   = 1'b0;
            out_valid_d  = 1'b1;
            // A single-beat block starts draining on its last beat.
            out_last_d   = (BEATS == 1);
          end else begin
            wr_cnt_d = wr_cnt_q + CW'(1);
          end
        end
      end
      DRAIN: begin
        if (out_xfer) begin
          if (rd_cnt_q == LAST_IDX) begin
            state_d     = LOAD;
            rd_cnt_d    = '0;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            blk_count_d = blk_count_q + 16'd1;
          end else begin
            rd_cnt_d   = rd_cnt_q + CW'(1);
            out_last_d = ((rd_cnt_q + CW'(1)) == LAST_IDX);
          end
        end
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= LOAD;
      wr_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      key_loaded_q <= 1'b0;
      reuse_q      <= 1'b0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      blk_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      key_loaded_q <= key_loaded_d;
      reuse_q      <= reuse_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      blk_count_q  <= blk_count_d;
    end
  end

  // Block buffers carry no reset; a discarded partial block is simply
  // overwritten by the next one.
  always_ff @(posedge clk) begin
    if (in_xfer) begin
      data_buf[wr_cnt_q] <= din;
    end
    if (key_we) begin
      key_buf[wr_cnt_q] <= key;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign blk_count = blk_count_q;
  assign dout      = add_key(data_buf[rd_cnt_q], key_buf[rd_cnt_q], out_valid_q);

endmodule
